// File: rtl/port_pkt_buffer.sv
// Per-port store-and-forward packet buffer: frames the port FSM's byte stream on
// wr_en falling edges, checks even parity per packet and exposes only whole packets.
module port_pkt_buffer #(
   parameter int W_WIDTH = 8,
   parameter int DEPTH   = 16,
   parameter int MAX_PKT = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [W_WIDTH-1:0]        data_in,
   input  logic                      rd_en,
   output logic [W_WIDTH-1:0]        data_out,
   output logic                      data_valid,
   output logic                      data_last,
   output logic                      port_busy,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    pkt_cnt,
   output logic                      par_err,
   output logic                      ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] MAX_PKT_C = CW'(MAX_PKT);
   localparam logic [AW-1:0] ONE_A     = AW'(1);

   // Each entry carries the data byte plus a last-of-packet flag in the MSB.
   logic [W_WIDTH:0] mem_q [DEPTH];

   logic [AW-1:0]      wptr_q, wptr_d;
   logic [AW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      pkt_cnt_q, pkt_cnt_d;
   logic               wr_en_dly_q, wr_en_dly_d;
   logic [W_WIDTH-1:0] acc_q, acc_d;
   logic               pkt_has_entry_q, pkt_has_entry_d;
   logic               par_err_q, par_err_d;
   logic               ovf_q, ovf_d;

   logic               pkt_start, pkt_close, do_write, pop, head_last, set_last;
   logic [W_WIDTH:0]   head;
   logic [AW-1:0]      last_idx;

   assign head       = mem_q[rptr_q];
   assign data_valid = (pkt_cnt_q != '0);
   assign head_last  = head[W_WIDTH];
   assign data_out   = data_valid ? head[W_WIDTH-1:0] : '0;
   assign data_last  = data_valid & head_last;
   assign full       = (count_q == DEPTH_C);
   assign empty      = (count_q == '0);
   assign port_busy  = ((DEPTH_C - count_q) < MAX_PKT_C);
   assign pkt_cnt    = pkt_cnt_q;
   assign par_err    = par_err_q;
   assign ovf        = ovf_q;

   // NOTE: every signal gets a default at the top of the block, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      pkt_start = wr_en & ~wr_en_dly_q;
      pkt_close = ~wr_en & wr_en_dly_q;
      do_write  = wr_en & ~full;
      pop       = rd_en & data_valid;
      set_last  = pkt_close & pkt_has_entry_q;
      last_idx  = wptr_q - ONE_A;

      wptr_d          = do_write ? wptr_q + ONE_A : wptr_q;
      rptr_d          = pop ? rptr_q + ONE_A : rptr_q;
      count_d         = count_q + CW'(do_write) - CW'(pop);
      pkt_cnt_d       = pkt_cnt_q + CW'(set_last) - CW'(pop & head_last);
      wr_en_dly_d     = wr_en;
      ovf_d           = ovf_q | (wr_en & full);
      par_err_d       = pkt_close & (acc_q != '0);

      acc_d           = acc_q;
      pkt_has_entry_d = pkt_has_entry_q;
      if (pkt_start) begin
         acc_d           = data_in;
         pkt_has_entry_d = do_write;
      end else if (wr_en) begin
         // Dropped bytes still enter the parity so a truncated packet is flagged.
         acc_d           = acc_q ^ data_in;
         pkt_has_entry_d = pkt_has_entry_q | do_write;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q          <= '0;
         rptr_q          <= '0;
         count_q         <= '0;
         pkt_cnt_q       <= '0;
         wr_en_dly_q     <= 1'b0;
         acc_q           <= '0;
         pkt_has_entry_q <= 1'b0;
         par_err_q       <= 1'b0;
         ovf_q           <= 1'b0;
      end else begin
         wptr_q          <= wptr_d;
         rptr_q          <= rptr_d;
         count_q         <= count_d;
         pkt_cnt_q       <= pkt_cnt_d;
         wr_en_dly_q     <= wr_en_dly_d;
         acc_q           <= acc_d;
         pkt_has_entry_q <= pkt_has_entry_d;
         par_err_q       <= par_err_d;
         ovf_q           <= ovf_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; pointers and counters
   // define which entries are meaningful, and outputs are gated by data_valid.
   always_ff @(posedge clk) begin
      if (do_write) mem_q[wptr_q] <= {1'b0, data_in};
      // Close never coincides with a write, so the flag update has the port to itself.
      if (set_last) mem_q[last_idx][W_WIDTH] <= 1'b1;
   end

endmodule

// File: doc/port_pkt_buffer.md
Name: port_pkt_buffer

Overview:
Per-port store-and-forward packet buffer that sits directly downstream of the port FSM in the switch. It captures the byte stream the FSM writes with wr_en, frames packets on wr_en falling edges, and checks even parity over each packet. It presents only complete packets to the output-port consumer through a show-ahead read interface. It drives port_busy back to the FSM so that no packet is started without room for it.

Parameters:
W_WIDTH, 8, data byte width; must match the FSM.
DEPTH, 16, number of buffer entries; power of 2, at least 2.
MAX_PKT, 8, maximum packet length in entries, address and parity bytes included; 1 ≤ MAX_PKT ≤ DEPTH.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
wr_en  in  1  write strobe from the port FSM; one packet per contiguous high run
data_in  in  W_WIDTH  byte written when wr_en=1
rd_en  in  1  consumer pop; honoured only when data_valid=1
data_out  out  W_WIDTH  head byte; 0 when data_valid=0
data_valid  out  1  head entry belongs to a complete packet
data_last  out  1  head entry is the final byte of its packet; 0 when data_valid=0
port_busy  out  1  free entries < MAX_PKT
full  out  1  count == DEPTH
empty  out  1  count == 0
pkt_cnt  out  $clog2(DEPTH)+1  complete packets held
par_err  out  1  one-cycle pulse: the packet just closed has bad parity
ovf  out  1  sticky: a byte was dropped because the buffer was full

Behaviour:
- Storage: DEPTH entries of W_WIDTH+1 bits (data plus last flag).
  - wptr and rptr are $clog2(DEPTH) bits wide and wrap naturally.
  - count is $clog2(DEPTH)+1 bits wide.
- Reset (rst_n=0 at a clk edge):
  - wptr, rptr, count, pkt_cnt, wr_en_d, the parity accumulator, pkt_has_entry, par_err and ovf are all cleared to 0.
  - Memory contents are not reset.
  - Resulting outputs: data_valid=0, data_out=0, data_last=0, empty=1, full=0, port_busy=0.
  - A reset mid-packet discards the partial packet; no pkt_cnt increment follows.
- wr_en_d is wr_en registered every cycle.
- Write, on a cycle with wr_en=1:
  - If full=0: store {last=0, data_in} at wptr, increment wptr and count, set pkt_has_entry=1.
  - If full=1: drop the byte and set ovf=1. ovf is cleared only by reset.
- Parity accumulator:
  - Packet start (wr_en=1 and wr_en_d=0): acc <= data_in and pkt_has_entry is reset, then updated by this cycle's write.
  - Subsequent cycles with wr_en=1: acc <= acc ^ data_in.
  - Dropped bytes are still XORed into acc.
- Packet close, on a cycle with wr_en=0 and wr_en_d=1:
  - If pkt_has_entry=1: set the last flag of entry wptr-1 and increment pkt_cnt.
  - par_err is 1 in the following cycle if acc != 0; it is 0 in every other cycle.
  - The parity byte is stored as ordinary data.
  - A packet whose bytes were all dropped produces no pkt_cnt change, but still gets its parity check.
- Delimiting: one wr_en-low cycle between packets is sufficient.
- Read (show-ahead):
  - data_valid = (pkt_cnt != 0).
  - data_out and data_last reflect mem[rptr], gated by data_valid.
  - On rd_en=1 with data_valid=1: increment rptr, decrement count, and decrement pkt_cnt if data_last=1.
  - rd_en while data_valid=0 is ignored; this includes an empty buffer and an incomplete head packet.
- Simultaneous events:
  - Write and pop in the same cycle: count is unchanged.
  - Packet close and a last-byte pop in the same cycle: pkt_cnt is unchanged.
  - The entry whose last flag is being set is never readable in that cycle.
- port_busy, full and empty are derived combinationally from the count register.
  - The FSM samples port_busy only at packet start.
  - port_busy does not abort a packet in flight.
- Read latency: 0 cycles from rd_en to the next head byte.
- First-byte latency: a packet's first byte becomes visible on data_out the cycle after its close cycle.

Test Plan:
- Good packet: after reset, write A5,3C,99 on consecutive cycles, then drop wr_en.
  - Next cycle: pkt_cnt=1, par_err=0, data_valid=1, data_out=A5.
  - Pop 3 times: data_last=1 only on 99; then empty=1, data_valid=0.
- Bad parity: write 11,22,00.
  - par_err pulses 1 for one cycle.
  - The packet is still stored and readable with pkt_cnt=1.
- Back-to-back packets: write packet P1 (01,02,03), one idle cycle, then P2 (10,20,30) while popping P1 concurrently.
  - count and pkt_cnt stay consistent.
  - pkt_cnt goes 1→0 at P1's last pop and →1 when P2 closes.
- Fill and overflow (DEPTH=16, MAX_PKT=8):
  - After 9 stored bytes: port_busy=1.
  - After 16 stored bytes: full=1.
  - The 17th byte is dropped, ovf=1 and count stays 16.
  - When wr_en falls, pkt_cnt=1 with last set on the 16th entry.
- Reset mid-packet: assert rst_n=0 during the 2nd byte of a packet.
  - All counters clear and data_valid=0.
  - The subsequent wr_en low does not increment pkt_cnt.
- Illegal pops: rd_en held high while empty, and while a packet is half written.
  - rptr, count and pkt_cnt are unchanged; data_out=0.
